// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA scan-out block: 640x480@60 timing,
// 160x120 framebuffer geometry and the 3-bit RGB pixel type.
package vga_pkg;

    // 640x480 timing, horizontal in pixel clocks and vertical in lines
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = 800;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = 525;

    // Framebuffer geometry: each pixel is replicated over a 4x4 screen block
    localparam int VGA_SCALE_SHIFT = 2;
    localparam int FB_WIDTH        = 160;
    localparam int FB_HEIGHT       = 120;
    localparam int FB_DEPTH        = 19200;

    // Counter and address widths (totals up to 1023, addresses up to 32767)
    localparam int CNT_W  = 10;
    localparam int ADDR_W = 15;

    typedef logic [2:0]        pixel_t;
    typedef logic [CNT_W-1:0]  count_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // A set colour bit drives its 4-bit channel to full scale
    function automatic logic [3:0] expand_channel(input logic bit_i);
        return bit_i ? 4'hF : 4'h0;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters plus the un-pipelined sync and
// visible-region flags derived from them.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [CNT_W-1:0] h_count_o,
    output logic [CNT_W-1:0] v_count_o,
    output logic             visible_o,
    output logic             hsync_n_o,
    output logic             vsync_n_o,
    output logic             line_end_o,
    output logic             frame_end_o
);

    localparam count_t H_VIS_C  = count_t'(H_VISIBLE);
    localparam count_t H_SYNC_S = count_t'(H_VISIBLE + H_FRONT);
    localparam count_t H_SYNC_E = count_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam count_t H_LAST   = count_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam count_t V_VIS_C  = count_t'(V_VISIBLE);
    localparam count_t V_SYNC_S = count_t'(V_VISIBLE + V_FRONT);
    localparam count_t V_SYNC_E = count_t'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam count_t V_LAST   = count_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    count_t h_q, h_d;
    count_t v_q, v_d;
    logic   line_end;
    logic   frame_end;

    // Next raster position: h wraps every line, v advances on each h wrap
    always_comb begin
        line_end  = (h_q == H_LAST);
        frame_end = line_end && (v_q == V_LAST);
        h_d       = line_end ? '0 : h_q + count_t'(1);
        v_d       = v_q;
        if (line_end) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + count_t'(1);
        end
    end

    // Counters park at (0,0) under reset or while scanning is disabled
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_count_o   = h_q;
    assign v_count_o   = v_q;
    assign line_end_o  = line_end;
    assign frame_end_o = frame_end;
    // Visible is gated by enable so a parked raster never fetches pixels
    assign visible_o   = enable && (h_q < H_VIS_C) && (v_q < V_VIS_C);
    assign hsync_n_o   = !((h_q >= H_SYNC_S) && (h_q < H_SYNC_E));
    assign vsync_n_o   = !((v_q >= V_SYNC_S) && (v_q < V_SYNC_E));

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: framebuffer address generation from the raster position and
// a one-cycle output pipeline keeping colour, syncs and frame_start aligned.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_VISIBLE   = VGA_H_VISIBLE,
    parameter int H_FRONT     = VGA_H_FRONT,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BACK      = VGA_H_BACK,
    parameter int V_VISIBLE   = VGA_V_VISIBLE,
    parameter int V_FRONT     = VGA_V_FRONT,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BACK      = VGA_V_BACK,
    parameter int SCALE_SHIFT = VGA_SCALE_SHIFT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [14:0] read_address,
    input  logic [2:0]  read_data,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start
);

    localparam count_t V_VIS_C    = count_t'(V_VISIBLE);
    localparam count_t SCALE_MASK = count_t'((1 << SCALE_SHIFT) - 1);

    count_t h_count;
    count_t v_count;
    logic   visible;
    logic   hsync_pre;
    logic   vsync_pre;
    logic   line_end;
    logic   frame_end;
    logic   frame_start_pre;

    addr_t  row_q, row_d;
    addr_t  last_q, last_d;
    addr_t  addr_cur;

    logic       hsync_q, vsync_q, vis_q, fs_q;
    logic [3:0] r_q, g_q, b_q;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .h_count_o   (h_count),
        .v_count_o   (v_count),
        .visible_o   (visible),
        .hsync_n_o   (hsync_pre),
        .vsync_n_o   (vsync_pre),
        .line_end_o  (line_end),
        .frame_end_o (frame_end)
    );

    assign frame_start_pre = visible && (h_count == '0) && (v_count == '0);

    // Address = row base + column; the row base steps by one framebuffer row
    // at the end of every 4th visible line instead of multiplying v by 160
    always_comb begin
        addr_cur     = row_q + addr_t'(h_count >> SCALE_SHIFT);
        read_address = visible ? addr_cur : last_q;
        last_d       = read_address;
        row_d        = row_q;
        if (frame_end) begin
            row_d = '0;
        end else if (line_end && (v_count < V_VIS_C) &&
                     ((v_count & SCALE_MASK) == SCALE_MASK)) begin
            row_d = row_q + addr_t'(FB_WIDTH);
        end
    end

    // Row base and held address clear with the raster
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            row_q  <= '0;
            last_q <= '0;
        end else begin
            row_q  <= row_d;
            last_q <= last_d;
        end
    end

    // ---- output stage: control flags delayed one cycle alongside the pixel
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            vis_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            hsync_q <= hsync_pre;
            vsync_q <= vsync_pre;
            vis_q   <= visible;
            fs_q    <= frame_start_pre;
        end
    end

    // Pixel data register; blanking is applied afterwards by the delayed flag
    always_ff @(posedge clk) begin
        r_q <= expand_channel(read_data[2]);
        g_q <= expand_channel(read_data[1]);
        b_q <= expand_channel(read_data[0]);
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;
    assign vga_r       = vis_q ? r_q : 4'h0;
    assign vga_g       = vis_q ? g_q : 4'h0;
    assign vga_b       = vis_q ? b_q : 4'h0;

endmodule
